hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage MIPS core. Drives stall (enable-hold)
//  and clear inputs of the F/D/E/M/W pipeline registers, forwarding muxes, and
//  sequences multi-cycle mult/div ops in E plus data-memory wait states in M.
//  Sits beside the datapath; all pipeline registers take stall/flush from here.
// PARAMETERS
//  MUL_LAT     4  cycles E is stalled for a multiply (>=2)
//  DIV_LAT     32 cycles E is stalled for a divide (>=2)
//  CNT_W       6  width of latency counter; must hold max(MUL_LAT,DIV_LAT)-1
//  DELAY_SLOT  1  1: branch delay slot, no D flush on taken branch/jump; 0: flush D
// PORTS
//  clk            in  1  clock, rising edge
//  rst            in  1  asynchronous reset, active-low
//  rsD,rtD        in  5  source regs of instr in D
//  rsE,rtE        in  5  source regs of instr in E
//  writeregE/M/W  in  5  dest reg in E/M/W
//  regwriteE/M/W  in  1  dest write enable in E/M/W
//  memtoregE/M    in  1  instr in E/M is a load
//  branchD        in  1  D holds a branch (compared in D)
//  pcsrcD,jumpD   in  1  branch taken / jump in D
//  mdu_startE     in  1  E holds mult/div (level, held while E stalled)
//  mdu_divE       in  1  1=divide, 0=multiply; valid with mdu_startE
//  mem_reqM       in  1  M has a data-memory access (level)
//  mem_ackM       in  1  data memory completes access this cycle
//  stallF,stallD,stallE,stallM  out 1  hold the stage register
//  flushD,flushE,flushM,flushW  out 1  clear the stage register (bubble)
//  forwardAD,forwardBD          out 1  forward ALUoutM to D comparator
//  forwardAE,forwardBE          out 2  E operand: 00 reg, 01 resultW, 10 ALUoutM
//  mdu_busy       out 1  state==MDU
//  mdu_done       out 1  mult/div result valid this cycle (state==MDU & cnt==0)
// BEHAVIOUR
//  State: FSM {RUN,MDU}, down-counter cnt[CNT_W-1:0]. rst low -> RUN, cnt=0
//   immediately (also mid-operation); mdu_busy=mdu_done=0. All other outputs comb.
//  memstall = mem_reqM & ~mem_ackM.
//  mdustall = (RUN & mdu_startE) | (MDU & cnt!=0).
//  lwstall  = memtoregE & (rtE==rsD | rtE==rtD).
//  brstall  = branchD & ((regwriteE & writeregE!=0 & writeregE in {rsD,rtD})
//             | (memtoregM & writeregM!=0 & writeregM in {rsD,rtD})).
//  Priority, first match wins, others 0:
//   1 memstall: stallF/D/E/M=1, flushW=1.
//   2 mdustall: stallF/D/E=1, flushM=1.
//   3 lwstall|brstall: stallF/D=1, flushE=1.
//   4 (pcsrcD|jumpD) & DELAY_SLOT==0: flushD=1.
//  Transitions:
//   RUN->MDU when mdu_startE & ~memstall; cnt<=(mdu_divE?DIV_LAT:MUL_LAT)-1.
//   RUN & mdu_startE & memstall: stay RUN, no load (op retried when memstall clears).
//   MDU: cnt decrements each cycle while cnt!=0, incl. under memstall.
//   MDU & cnt==0 & ~memstall -> RUN. If memstall, hold MDU, mdu_done stays 1.
//  Latency: op with LAT stalls E exactly LAT cycles; leaves E on the done cycle
//   (E occupancy LAT+1 cycles absent memstall). mdu_done is 1-cycle pulse then.
//  Forwarding (reg 0 never forwarded): forwardAE=10 if regwriteM&writeregM==rsE;
//   else 01 if regwriteW&writeregW==rsE; else 00. BE same with rtE. M beats W.
//   forwardAD = rsD!=0 & regwriteM & writeregM==rsD; BD same with rtD.
//  Forwarding outputs are independent of stall priority.
// TESTING
//  1 lw $2 in E (memtoregE=1,rtE=2), rsD=2 -> stallF=stallD=flushE=1 one cycle; next cycle 0.
//  2 mdu_startE,mdu_divE=1,DIV_LAT=32 -> stallE=1 for 32 cycles, mdu_done=1 on cycle 33, then RUN.
//  3 MUL in MDU with cnt=0 while mem_reqM=1,mem_ackM=0 for 3 cycles -> stallM=1,flushW=1,
//    mdu_done held 3 cycles; ack -> RUN next edge.
//  4 mdu_startE and memstall same cycle -> state stays RUN, cnt unchanged; ack -> MDU next edge.
//  5 regwriteM=regwriteW=1, writeregM=writeregW=rsE=5 -> forwardAE=10; rsE=0 -> 00.
//  6 rst low mid-divide (cnt=17) -> state RUN, cnt=0, mdu_busy=0 before next clk edge.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage core: stall/flush control for every pipeline
// register, operand forwarding selects, and sequencing of multi-cycle mult/div in E.
module hazard_sched #(
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 6,
    parameter int DELAY_SLOT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       pcsrcD,
    input  logic       jumpD,
    input  logic       mdu_startE,
    input  logic       mdu_divE,
    input  logic       mem_reqM,
    input  logic       mem_ackM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mdu_busy,
    output logic       mdu_done
);

    typedef enum logic {RUN, MDU} state_t;

    // The counter holds the remaining stall cycles after the accepting cycle.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic memstall, mdustall, lwstall, brstall, cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign memstall = mem_reqM & ~mem_ackM;
    assign mdustall = ((state == RUN) & mdu_startE) | ((state == MDU) & ~cnt_zero);
    assign lwstall  = memtoregE & ((rtE == rsD) | (rtE == rtD));
    assign brstall  = branchD &
                      ((regwriteE & (writeregE != 5'd0) & ((writeregE == rsD) | (writeregE == rtD))) |
                       (memtoregM & (writeregM != 5'd0) & ((writeregM == rsD) | (writeregM == rtD))));

    assign mdu_busy = (state == MDU);
    assign mdu_done = (state == MDU) & cnt_zero;

    // A start seen under a memory stall is not accepted; E still holds the op,
    // so it is picked up again once the stall clears.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_startE && !memstall) begin
                        state <= MDU;
                        cnt   <= mdu_divE ? DIV_CNT : MUL_CNT;
                    end
                end
                MDU: begin
                    if (!cnt_zero)
                        cnt <= cnt - CNT_ONE;
                    else if (!memstall)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (memstall) begin
            {stallF, stallD, stallE, stallM} = 4'b1111;
            flushW = 1'b1;
        end else if (mdustall) begin
            {stallF, stallD, stallE} = 3'b111;
            flushM = 1'b1;
        end else if (lwstall || brstall) begin
            {stallF, stallD} = 2'b11;
            flushE = 1'b1;
        end else if ((pcsrcD || jumpD) && DELAY_SLOT == 0) begin
            flushD = 1'b1;
        end
    end

    // Forwarding is independent of stalls; the M stage is the younger result.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != 5'd0 && regwriteM && writeregM == rsE)
            forwardAE = 2'b10;
        else if (rsE != 5'd0 && regwriteW && writeregW == rsE)
            forwardAE = 2'b01;
        if (rtE != 5'd0 && regwriteM && writeregM == rtE)
            forwardBE = 2'b10;
        else if (rtE != 5'd0 && regwriteW && writeregW == rtE)
            forwardBE = 2'b01;
    end

    assign forwardAD = (rsD != 5'd0) & regwriteM & (writeregM == rsD);
    assign forwardBD = (rtD != 5'd0) & regwriteM & (writeregM == rtD);

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: combinational vector table, hand-written
// multi-cycle sequences, and a randomized run against a cycle-age reference model.
module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, pcsrcD, jumpD, mdu_startE, mdu_divE, mem_reqM, mem_ackM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
    logic       forwardAD, forwardBD, mdu_busy, mdu_done;
    logic [1:0] forwardAE, forwardBE;

    int checks = 0;
    int errors = 0;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    hazard_sched dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
        .mdu_startE(mdu_startE), .mdu_divE(mdu_divE),
        .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    always #5 clk = ~clk;

    // {stallF,stallD,stallE,stallM, flushD,flushE,flushM,flushW, fAD,fBD, fAE, fBE, busy,done}
    logic [15:0] outs;
    assign outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
                   forwardAD, forwardBD, forwardAE, forwardBE, mdu_busy, mdu_done};

    typedef struct {
        string       name;
        logic [4:0]  rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic        rw_e, rw_m, rw_w, mt_e, mt_m, br_d, pc_d, start, req, ack;
        logic [15:0] expect_o;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
        branchD = 0; pcsrcD = 0; jumpD = 0; mdu_startE = 0; mdu_divE = 0;
        mem_reqM = 0; mem_ackM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an accepted op is tracked by its age in cycles since
    // acceptance; E is stalled until the age reaches the op latency.
    bit m_active;
    int m_age, m_lat;

    function automatic logic [15:0] model_out();
        logic ms, mds, lw, br, hit_e, hit_m;
        logic [3:0] st;
        logic [3:0] fl;
        logic [1:0] fae, fbe;
        ms    = mem_reqM && !mem_ackM;
        mds   = m_active ? (m_age < m_lat) : mdu_startE;
        lw    = memtoregE && (rtE == rsD || rtE == rtD);
        hit_e = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        hit_m = memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
        br    = branchD && (hit_e || hit_m);
        st = 4'b0000; fl = 4'b0000;
        if (ms)            begin st = 4'b1111; fl = 4'b0001; end
        else if (mds)      begin st = 4'b1110; fl = 4'b0010; end
        else if (lw || br) begin st = 4'b1100; fl = 4'b0100; end
        fae = (rsE != 0 && regwriteM && writeregM == rsE) ? 2'b10 :
              (rsE != 0 && regwriteW && writeregW == rsE) ? 2'b01 : 2'b00;
        fbe = (rtE != 0 && regwriteM && writeregM == rtE) ? 2'b10 :
              (rtE != 0 && regwriteW && writeregW == rtE) ? 2'b01 : 2'b00;
        return {st, fl,
                logic'(rsD != 0 && regwriteM && writeregM == rsD),
                logic'(rtD != 0 && regwriteM && writeregM == rtD),
                fae, fbe, logic'(m_active), logic'(m_active && m_age >= m_lat)};
    endfunction

    task automatic model_step();
        bit ms;
        ms = mem_reqM && !mem_ackM;
        if (!m_active) begin
            if (mdu_startE && !ms) begin
                m_active = 1; m_age = 1; m_lat = mdu_divE ? DIV_LAT : MUL_LAT;
            end
        end else if (m_age >= m_lat && !ms) begin
            m_active = 0;
        end else begin
            m_age++;
        end
    endtask

    vec_t vecs[14];

    initial begin
        bit seen;
        idle();
        vecs[0]  = '{"reset_idle", 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 16'h0000};
        vecs[1]  = '{"lwstall",    2,0,0,2,0,0,0, 0,0,0,1,0,0,0,0,0,0, 16'hC400};
        vecs[2]  = '{"fwdAE_M",    0,0,5,0,0,5,5, 0,1,1,0,0,0,0,0,0,0, 16'h0020};
        vecs[3]  = '{"fwd_r0",     0,0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,0, 16'h0000};
        vecs[4]  = '{"fwdBE_W",    0,0,0,7,0,0,7, 0,0,1,0,0,0,0,0,0,0, 16'h0004};
        vecs[5]  = '{"memstall",   0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0, 16'hF100};
        vecs[6]  = '{"mem_acked",  0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1, 16'h0000};
        vecs[7]  = '{"brstall_E",  3,0,0,0,3,0,0, 1,0,0,0,0,1,0,0,0,0, 16'hC400};
        vecs[8]  = '{"br_r0",      0,0,0,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 16'h0000};
        vecs[9]  = '{"brstall_M",  0,4,0,0,0,4,0, 0,0,0,0,1,1,0,0,0,0, 16'hC400};
        vecs[10] = '{"fwdAD",      6,0,0,0,0,6,0, 0,1,0,0,0,0,0,0,0,0, 16'h0080};
        vecs[11] = '{"taken_slot", 0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0, 16'h0000};
        vecs[12] = '{"prio_mem",   2,0,0,2,0,0,0, 0,0,0,1,0,0,0,1,1,0, 16'hF100};
        vecs[13] = '{"mdu_run",    0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,0, 16'hE200};

        // Table runs with reset held so the FSM stays in RUN regardless of clock edges.
        #2;
        for (int i = 0; i < 14; i++) begin
            rsD = vecs[i].rs_d; rtD = vecs[i].rt_d; rsE = vecs[i].rs_e; rtE = vecs[i].rt_e;
            writeregE = vecs[i].wr_e; writeregM = vecs[i].wr_m; writeregW = vecs[i].wr_w;
            regwriteE = vecs[i].rw_e; regwriteM = vecs[i].rw_m; regwriteW = vecs[i].rw_w;
            memtoregE = vecs[i].mt_e; memtoregM = vecs[i].mt_m; branchD = vecs[i].br_d;
            pcsrcD = vecs[i].pc_d; mdu_startE = vecs[i].start;
            mem_reqM = vecs[i].req; mem_ackM = vecs[i].ack;
            #1;
            check(vecs[i].name, outs, vecs[i].expect_o);
            idle();
        end

        @(negedge clk); rst = 1;
        tick();

        // Load-use stall lasts one cycle.
        memtoregE = 1; rtE = 2; rsD = 2;
        #1 check("lw_cycle1", outs, 16'hC400);
        tick();
        idle();
        #1 check("lw_cycle2", outs, 16'h0000);

        // Divide: E stalled exactly DIV_LAT cycles, done pulse on the next.
        mdu_startE = 1; mdu_divE = 1;
        for (int i = 0; i < DIV_LAT; i++) begin
            #1 check("div_stall", {14'd0, stallE, mdu_done}, 16'h0002);
            tick();
        end
        #1 check("div_done", outs, 16'h0003);
        idle();
        tick();
        #1 check("div_back_run", outs, 16'h0000);

        // Multiply completes while M waits on memory: done held, then RUN after ack.
        mdu_startE = 1; mdu_divE = 0;
        repeat (MUL_LAT) tick();
        mem_reqM = 1; mem_ackM = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mul_memwait", outs, 16'hF103);
            tick();
        end
        mem_ackM = 1;
        #1 check("mul_ack", outs, 16'h0003);
        tick();
        idle();
        #1 check("mul_back_run", outs, 16'h0000);

        // Start coincides with a memory stall: not accepted until the stall clears.
        mdu_startE = 1; mdu_divE = 0; mem_reqM = 1; mem_ackM = 0;
        #1 check("start_memstall", outs, 16'hF100);
        tick();
        #1 check("start_still_run", outs, 16'hF100);
        mem_ackM = 1;
        #1 check("start_accept", outs, 16'hE200);
        tick();
        #1 check("start_in_mdu", outs, 16'hE202);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (mdu_done) seen = 1;
        end
        check("start_done_seen", {15'd0, seen}, 16'h0001);
        idle();
        tick();

        // Asynchronous reset in the middle of a divide.
        mdu_startE = 1; mdu_divE = 1;
        repeat (15) tick();
        #1 check("div_mid_busy", {14'd0, mdu_busy, mdu_done}, 16'h0002);
        #1 rst = 0;
        #1 check("div_mid_reset", {14'd0, mdu_busy, mdu_done}, 16'h0000);
        idle();
        @(negedge clk); rst = 1;
        tick();
        #1 check("after_reset", outs, 16'h0000);

        // Randomized run against the reference model.
        @(negedge clk); rst = 0;
        m_active = 0; m_age = 0; m_lat = MUL_LAT;
        @(negedge clk); rst = 1;
        tick();
        for (int i = 0; i < 2000; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
            branchD = 1'($urandom); pcsrcD = 1'($urandom); jumpD = 1'($urandom);
            mdu_startE = ($urandom_range(0, 3) == 0); mdu_divE = ($urandom_range(0, 3) == 0);
            mem_reqM = ($urandom_range(0, 3) == 0); mem_ackM = 1'($urandom);
            #1 check("random", outs, model_out());
            model_step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
